// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32 control unit: FSM states, ALU ops,
// opcodes and datapath mux selects.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
  } state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_ctrl_e;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_ITYPE  = 7'b0010011,
    OP_BRANCH = 7'b1100011,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef enum logic [2:0] {IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_J = 3'd3, IMM_U = 3'd4} imm_src_e;
  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2, SRCA_ZERO = 2'd3} src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} src_b_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_DATA = 2'd1, RES_ALURESULT = 2'd2} result_src_e;

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath bundle: instruction fields and flags in, control strobes out.
interface multicycle_controller_if;
  logic [6:0] op_i;
  logic [2:0] funct3_i;
  logic       funct7b5_i;
  logic       Zero_i;
  logic       Lt_i;
  logic       Ltu_i;
  logic       MemReady_i;
  logic       PCWrite_o;
  logic       AdrSrc_o;
  logic       IRWrite_o;
  logic       MemWrite_o;
  logic       RegWrite_o;
  logic [1:0] ResultSrc_o;
  logic [1:0] ALUSrcA_o;
  logic [1:0] ALUSrcB_o;
  logic [2:0] ImmSrc_o;
  logic [3:0] ALUControl_o;
  logic       Illegal_o;

  modport master (
    output op_i, funct3_i, funct7b5_i, Zero_i, Lt_i, Ltu_i, MemReady_i,
    input  PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o, ResultSrc_o,
           ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, Illegal_o
  );

  modport slave (
    input  op_i, funct3_i, funct7b5_i, Zero_i, Lt_i, Ltu_i, MemReady_i,
    output PCWrite_o, AdrSrc_o, IRWrite_o, MemWrite_o, RegWrite_o, ResultSrc_o,
           ALUSrcA_o, ALUSrcB_o, ImmSrc_o, ALUControl_o, Illegal_o
  );
endinterface

// File: rtl/mc_aludec.sv
// funct3/funct7b5 -> ALU operation for R- and I-type ALU instructions.
module mc_aludec
  import mc_pkg::*;
(
  input  logic      [2:0] funct3_i,
  input  logic            funct7b5_i,
  input  logic            is_rtype_i,
  output alu_ctrl_e       alu_ctrl_o,
  output logic            illegal_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    // Only add/sub and srl/sra have a funct7 variant; bit 30 elsewhere in R-type is reserved.
    illegal_o  = is_rtype_i && funct7b5_i && (funct3_i != 3'b000) && (funct3_i != 3'b101);
    case (funct3_i)
      3'b000:  alu_ctrl_o = (is_rtype_i && funct7b5_i) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_ctrl_o = ALU_SLL;
      3'b010:  alu_ctrl_o = ALU_SLT;
      3'b011:  alu_ctrl_o = ALU_SLTU;
      3'b100:  alu_ctrl_o = ALU_XOR;
      3'b101:  alu_ctrl_o = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  alu_ctrl_o = ALU_OR;
      default: alu_ctrl_o = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I main control FSM; all outputs decode the current state
// (plus memory-ready, branch flags and funct fields), none are registered.
module multicycle_controller
  import mc_pkg::*;
#(
  parameter bit EXT_BRANCH = 1'b1,
  parameter bit MEM_WAIT   = 1'b1
) (
  input logic                    clk_i,
  input logic                    reset_i,
  multicycle_controller_if.slave ctrl
);

  state_e      state_q, state_d;
  logic        mem_ready, br_taken, br_illegal, dec_illegal;
  alu_ctrl_e   dec_alu, alu_ctrl;
  logic        pc_write, adr_src, ir_write, mem_write, reg_write, illegal;
  result_src_e result_src;
  src_a_e      src_a;
  src_b_e      src_b;
  imm_src_e    imm_src;

  mc_aludec u_aludec (
    .funct3_i   (ctrl.funct3_i),
    .funct7b5_i (ctrl.funct7b5_i),
    .is_rtype_i (ctrl.op_i == OP_RTYPE),
    .alu_ctrl_o (dec_alu),
    .illegal_o  (dec_illegal)
  );

  assign mem_ready  = MEM_WAIT ? ctrl.MemReady_i : 1'b1;
  assign br_illegal = (ctrl.funct3_i[2:1] == 2'b01) || (!EXT_BRANCH && (ctrl.funct3_i != 3'b000));

  always_comb begin
    case (ctrl.funct3_i)
      3'b000:  br_taken = ctrl.Zero_i;
      3'b001:  br_taken = !ctrl.Zero_i;
      3'b100:  br_taken = ctrl.Lt_i;
      3'b101:  br_taken = !ctrl.Lt_i;
      3'b110:  br_taken = ctrl.Ltu_i;
      3'b111:  br_taken = !ctrl.Ltu_i;
      default: br_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    result_src = RES_ALUOUT;
    src_a      = SRCA_PC;
    src_b      = SRCB_RS2;
    imm_src    = IMM_I;
    alu_ctrl   = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        src_b      = SRCB_FOUR;
        result_src = RES_ALURESULT;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch target is precomputed here so BRANCH only has to compare.
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = IMM_B;
        case (ctrl.op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_LUI:            state_d = S_LUI;
          OP_AUIPC:          state_d = S_AUIPC;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        src_a   = SRCA_RS1;
        src_b   = SRCB_IMM;
        imm_src = (ctrl.op_i == OP_STORE) ? IMM_S : IMM_I;
        state_d = (ctrl.op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECR: begin
        src_a    = SRCA_RS1;
        alu_ctrl = dec_alu;
        // A reserved funct7 encoding must not reach writeback.
        illegal  = dec_illegal;
        state_d  = dec_illegal ? S_FETCH : S_ALUWB;
      end
      S_EXECI: begin
        src_a    = SRCA_RS1;
        src_b    = SRCB_IMM;
        alu_ctrl = dec_alu;
        state_d  = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        src_a    = SRCA_RS1;
        alu_ctrl = ALU_SUB;
        illegal  = br_illegal;
        pc_write = br_taken && !br_illegal;
        state_d  = S_FETCH;
      end
      S_JAL: begin
        src_a    = SRCA_OLDPC;
        src_b    = SRCB_FOUR;
        pc_write = 1'b1;
        state_d  = S_ALUWB;
      end
      S_JALR: begin
        // PC takes rs1+imm now; S_JAL then rewrites it from ALUOut (same target) and forms the link.
        src_a      = SRCA_RS1;
        src_b      = SRCB_IMM;
        result_src = RES_ALURESULT;
        pc_write   = 1'b1;
        state_d    = S_JAL;
      end
      S_LUI: begin
        src_a   = SRCA_ZERO;
        src_b   = SRCB_IMM;
        imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      S_AUIPC: begin
        src_a   = SRCA_OLDPC;
        src_b   = SRCB_IMM;
        imm_src = IMM_U;
        state_d = S_ALUWB;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign ctrl.PCWrite_o    = pc_write  && !reset_i;
  assign ctrl.IRWrite_o    = ir_write  && !reset_i;
  assign ctrl.MemWrite_o   = mem_write && !reset_i;
  assign ctrl.RegWrite_o   = reg_write && !reset_i;
  assign ctrl.Illegal_o    = illegal   && !reset_i;
  assign ctrl.AdrSrc_o     = adr_src;
  assign ctrl.ResultSrc_o  = result_src;
  assign ctrl.ALUSrcA_o    = src_a;
  assign ctrl.ALUSrcB_o    = src_b;
  assign ctrl.ImmSrc_o     = imm_src;
  assign ctrl.ALUControl_o = alu_ctrl;

endmodule
